// File: rtl/microcode_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// microcode_pkg
// Shared definitions for the microcode sequencer:
//   - seq_state_e   : sequencer FSM states (IDLE, EXEC)
//   - *_DEF         : default widths used by the sequencer and its interface
//   - last_idx()    : bit position of the "last step" flag in a store word
//   - store_addr()  : control-store address layout {opcode, flags, upc}
//   - nop_word()    : reset value of every store word (single-step NOP)
// ----------------------------------------------------------------------------
package microcode_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } seq_state_e;

   localparam int OPCODE_W_DEF = 4;
   localparam int FLAG_W_DEF   = 2;
   localparam int UPC_W_DEF    = 2;
   localparam int CTRL_W_DEF   = 13;

   // The "last" flag sits directly above the control bits.
   function automatic int last_idx(input int ctrl_w);
      return ctrl_w;
   endfunction

   // Address layout: opcode in the top field, flags in the middle, micro-step
   // counter in the low bits, so one instruction's steps are contiguous.
   function automatic logic [31:0] store_addr(input logic [31:0] op,
                                              input logic [31:0] fl,
                                              input logic [31:0] upc,
                                              input int          flag_w,
                                              input int          upc_w);
      return (op << (flag_w + upc_w)) | (fl << upc_w) | upc;
   endfunction

   // {last=1, ctrl=0}: a one-cycle instruction that drives nothing.
   function automatic logic [63:0] nop_word(input int ctrl_w);
      return 64'd1 << ctrl_w;
   endfunction

endpackage

// File: rtl/microcode_sequencer_if.sv
// ----------------------------------------------------------------------------
// microcode_sequencer_if
// Bundles the instruction handshake, stall, control-word output and
// control-store programming port of the microcode sequencer.
//   master : instruction source / programmer (drives instr_*, hold, prog_*)
//   slave  : the sequencer (drives instr_ready, ctrl_*, prog_ready, seq_error)
// ----------------------------------------------------------------------------
interface microcode_sequencer_if #(
   parameter int OPCODE_W = microcode_pkg::OPCODE_W_DEF,
   parameter int FLAG_W   = microcode_pkg::FLAG_W_DEF,
   parameter int UPC_W    = microcode_pkg::UPC_W_DEF,
   parameter int CTRL_W   = microcode_pkg::CTRL_W_DEF
);
   localparam int AW = OPCODE_W + FLAG_W + UPC_W;
   localparam int WW = CTRL_W + 1;

   logic                instr_valid;
   logic                instr_ready;
   logic [OPCODE_W-1:0] opcode;
   logic [FLAG_W-1:0]   flags;
   logic                hold;
   logic                ctrl_valid;
   logic [CTRL_W-1:0]   ctrl_out;
   logic                prog_we;
   logic [AW-1:0]       prog_addr;
   logic [WW-1:0]       prog_data;
   logic                prog_ready;
   logic                seq_error;

   modport master (
      output instr_valid, opcode, flags, hold, prog_we, prog_addr, prog_data,
      input  instr_ready, ctrl_valid, ctrl_out, prog_ready, seq_error
   );

   modport slave (
      input  instr_valid, opcode, flags, hold, prog_we, prog_addr, prog_data,
      output instr_ready, ctrl_valid, ctrl_out, prog_ready, seq_error
   );

endinterface

// File: rtl/microcode_sequencer_control_store.sv
// ----------------------------------------------------------------------------
// control_store
// Writable microcode store: 2^AW words of WW bits held in registers.
// Asynchronous reset returns every word to NOP_WORD.
//   clk, reset_n : clock, asynchronous active-low reset
//   we_i         : write strobe (already qualified by the sequencer)
//   waddr_i      : write address
//   wdata_i      : write data
//   raddr_i      : read address
//   rdata_o      : combinational read data
// ----------------------------------------------------------------------------
module control_store #(
   parameter int          AW       = 8,
   parameter int          WW       = 14,
   parameter logic [WW-1:0] NOP_WORD = '0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [WW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [WW-1:0] rdata_o
);

   logic [WW-1:0] mem_q [2**AW];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2**AW; i++) begin
            mem_q[i] <= NOP_WORD;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/microcode_sequencer.sv
// ----------------------------------------------------------------------------
// microcode_sequencer
// Programmable microcode sequencer. An accepted instruction latches its
// opcode and flags; each EXEC cycle presents store[{op, flags, upc}] on the
// datapath control lines until a word marked "last" (or the final micro-step)
// retires it. A hold input freezes the current step.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : instr_valid/instr_ready/opcode/flags handshake, hold,
//                  ctrl_valid/ctrl_out, prog_we/prog_addr/prog_data/prog_ready,
//                  sticky seq_error
// ----------------------------------------------------------------------------
module microcode_sequencer
   import microcode_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_DEF,
   parameter int FLAG_W   = FLAG_W_DEF,
   parameter int UPC_W    = UPC_W_DEF,
   parameter int CTRL_W   = CTRL_W_DEF
) (
   input logic                  clk,
   input logic                  reset_n,
   microcode_sequencer_if.slave bus
);

   localparam int              AW       = OPCODE_W + FLAG_W + UPC_W;
   localparam int              WW       = CTRL_W + 1;
   localparam int              LAST     = last_idx(CTRL_W);
   localparam logic [63:0]     NOP64    = nop_word(CTRL_W);
   localparam logic [WW-1:0]   NOP_WORD = NOP64[WW-1:0];
   localparam logic [UPC_W-1:0] UPC_MAX = '1;
   localparam logic [UPC_W-1:0] UPC_ONE = UPC_W'(1);

   seq_state_e          state_q, state_d;
   logic [UPC_W-1:0]    upc_q, upc_d;
   logic [OPCODE_W-1:0] op_q, op_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;
   logic                err_q, err_d;

   logic [31:0]         raddr_full_unused;
   logic [AW-1:0]       raddr;
   logic [WW-1:0]       word;
   logic                word_last;
   logic                store_we;

   logic                instr_ready;
   logic                ctrl_valid;
   logic [CTRL_W-1:0]   ctrl_out;
   logic                prog_ready;

   assign raddr_full_unused = store_addr(32'(op_q), 32'(flags_q), 32'(upc_q),
                                         FLAG_W, UPC_W);
   assign raddr     = raddr_full_unused[AW-1:0];
   assign word_last = word[LAST];

   control_store #(
      .AW       (AW),
      .WW       (WW),
      .NOP_WORD (NOP_WORD)
   ) u_store (
      .clk     (clk),
      .reset_n (reset_n),
      .we_i    (store_we),
      .waddr_i (bus.prog_addr),
      .wdata_i (bus.prog_data),
      .raddr_i (raddr),
      .rdata_o (word)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         upc_q   <= '0;
         op_q    <= '0;
         flags_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         upc_q   <= upc_d;
         op_q    <= op_d;
         flags_q <= flags_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      upc_d       = upc_q;
      op_d        = op_q;
      flags_d     = flags_q;
      err_d       = err_q;
      instr_ready = 1'b0;
      ctrl_valid  = 1'b0;
      ctrl_out    = '0;
      prog_ready  = 1'b0;
      store_we    = 1'b0;

      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            prog_ready  = 1'b1;
            // A write and an accept in the same cycle both take effect; the
            // first micro-step then reads the freshly written word.
            store_we    = bus.prog_we;
            if (bus.instr_valid) begin
               state_d = EXEC;
               upc_d   = '0;
               op_d    = bus.opcode;
               flags_d = bus.flags;
            end
         end
         EXEC: begin
            // The store cannot change under a running micro-program.
            if (bus.prog_we) begin
               err_d = 1'b1;
            end
            if (!bus.hold) begin
               ctrl_valid = 1'b1;
               ctrl_out   = word[CTRL_W-1:0];
               if (word_last || (upc_q == UPC_MAX)) begin
                  instr_ready = 1'b1;
                  // Running off the end of the step range without a "last"
                  // marker means the micro-program is malformed.
                  if (!word_last) begin
                     err_d = 1'b1;
                  end
                  if (bus.instr_valid) begin
                     upc_d   = '0;
                     op_d    = bus.opcode;
                     flags_d = bus.flags;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  upc_d = upc_q + UPC_ONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.instr_ready = instr_ready;
   assign bus.ctrl_valid  = ctrl_valid;
   assign bus.ctrl_out    = ctrl_out;
   assign bus.prog_ready  = prog_ready;
   assign bus.seq_error   = err_q;

endmodule
